heartbeat_monitor: RTL
======================

// Module: heartbeat_monitor
// PURPOSE
//  Watchdog that consumes the single-cycle pulse from the heartbeat generator.
//  Locks onto the pulse stream and measures the beat interval.
//  Flags early and missing beats; raises a sticky alarm after MISS_LIMIT consecutive faults.
//  Sits directly downstream of the heartbeat generator; alarm feeds the SoC status/IRQ logic.
// PARAMETERS
//  W          16   width of gap counter and period output; counter saturates at 2^W-1
//  TIMEOUT    300  max cycles between beats before a miss; MIN_PERIOD < TIMEOUT <= 2^W-1
//  MIN_PERIOD 200  beats arriving at an interval below this are early faults; >= 1
//  MISS_LIMIT 3    consecutive faults that trigger alarm; >= 1
//  CW         2    width of miss_count; must hold MISS_LIMIT
// PORTS
//  clk          in   1    clock
//  reset        in   1    synchronous, active-high reset
//  hb_in        in   1    heartbeat pulse (level; rising edge = beat)
//  alarm_clr    in   1    clears alarm, returns FSM to SEARCH
//  alive        out  1    1 while in ACTIVE
//  alarm        out  1    1 while in ALARM (sticky)
//  early        out  1    1-cycle pulse on an early beat
//  miss_count   out  CW   consecutive fault count, saturates at MISS_LIMIT
//  period       out  W    last measured beat interval, in cycles
//  period_vld   out  1    set once two beats have been seen; cleared by reset/alarm_clr
// BEHAVIOUR
//  - Clock is clk; reset is synchronous and active-high on port reset.
//  - Reset: all outputs 0; hb_q=0, gap=0, state=SEARCH. Reset mid-operation gives the same result next cycle.
//  - Beat detection: beat = hb_in & ~hb_q, with hb_q a 1-cycle delay of hb_in.
//  - All outputs are registered. A beat at cycle t is visible on outputs at t+1.
//  - gap:
//    - cleared to 0 on a beat, on a miss, and on alarm_clr.
//    - otherwise increments each cycle, saturating at 2^W-1.
//    - interval of a beat = gap+1.
//  - Miss: gap==TIMEOUT-1 with no beat, i.e. TIMEOUT cycles after the last beat.
//    - A beat arriving on that same cycle wins; no miss, interval=TIMEOUT.
//  - States: SEARCH, ACTIVE, LATE, ALARM.
//    - SEARCH: no timeouts counted.
//      - beat -> ACTIVE (period not updated).
//    - ACTIVE:
//      - beat with interval>=MIN_PERIOD: stay in ACTIVE; period=interval; period_vld=1.
//      - beat with interval<MIN_PERIOD: early=1; period=interval; miss_count+1; -> LATE.
//      - miss: miss_count+1; -> LATE.
//    - LATE: same fault rules as ACTIVE.
//      - good beat (interval>=MIN_PERIOD) -> ACTIVE; miss_count=0.
//    - Any fault that brings miss_count to MISS_LIMIT -> ALARM (from ACTIVE or LATE).
//    - ALARM: beats still update period; early/miss no longer counted; leaves only via alarm_clr.
//  - alarm_clr has priority over a beat in the same cycle.
//    - -> SEARCH; miss_count, period_vld and gap cleared; the beat is ignored.
//    - alarm_clr outside ALARM gives the same result (resync).
//  - period holds its value between beats.
// STRUCTURE
//  - heartbeat_pkg: state encoding localparams (SEARCH=0, ACTIVE=1, LATE=2, ALARM=3); default TIMEOUT/MIN_PERIOD.
//  - Sub-module heartbeat_gapcnt: W-bit saturating counter with sync clear; outputs gap and at_timeout.
//  - Top level holds the edge detector, FSM, miss counter and period register.
// TESTING
//  1. Reset; pulse hb_in 1 cycle every 256 cycles (heartbeat N=8).
//     -> alive=1 one cycle after the first beat; period=256, period_vld=1 after the second; miss_count stays 0.
//  2. After lock, stop pulses.
//     -> miss_count=1, alive=0 at last_beat+301.
//     -> resume at interval 256: alive=1, miss_count=0.
//  3. Stop pulses permanently.
//     -> miss_count=1,2,3 at +301/+601/+901; alarm=1 at +901 and stays with beats resumed.
//     -> alarm_clr -> alarm=0, state SEARCH, period_vld=0.
//  4. Beat at interval 100 while ACTIVE.
//     -> early=1 for exactly 1 cycle, period=100, miss_count=1, alive=0.
//     -> next beat at 256: alive=1, miss_count=0.
//  5. Beat exactly TIMEOUT (300) cycles after the previous one -> no miss, period=300.
//     alarm_clr coincident with a beat in ALARM -> SEARCH, period unchanged.
//  6. hb_in held high 1000 cycles -> one beat only, then misses.
//     Reset asserted while in LATE -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/heartbeat_pkg.sv
// Shared types and default parameters for the heartbeat monitor.
package heartbeat_pkg;

    // Monitor FSM states; the encoding is fixed so status readback stays stable.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ACTIVE = 2'd1,
        LATE   = 2'd2,
        ALARM  = 2'd3
    } hb_state_e;

    localparam int unsigned HB_DEF_W          = 16;
    localparam int unsigned HB_DEF_TIMEOUT    = 300;
    localparam int unsigned HB_DEF_MIN_PERIOD = 200;
    localparam int unsigned HB_DEF_MISS_LIMIT = 3;
    localparam int unsigned HB_DEF_CW         = 2;

endpackage

// File: rtl/heartbeat_monitor_if.sv
// Heartbeat monitor signal bundle: pulse and clear in, status out.
interface heartbeat_monitor_if
    import heartbeat_pkg::*;
#(
    parameter int unsigned W  = HB_DEF_W,
    parameter int unsigned CW = HB_DEF_CW
) ();

    logic          hb_in;
    logic          alarm_clr;
    logic          alive;
    logic          alarm;
    logic          early;
    logic [CW-1:0] miss_count;
    logic [W-1:0]  period;
    logic          period_vld;

    // Side that drives the heartbeat and reads the status.
    modport master (
        output hb_in,
        output alarm_clr,
        input  alive,
        input  alarm,
        input  early,
        input  miss_count,
        input  period,
        input  period_vld
    );

    // The monitor itself.
    modport slave (
        input  hb_in,
        input  alarm_clr,
        output alive,
        output alarm,
        output early,
        output miss_count,
        output period,
        output period_vld
    );

endinterface

// File: rtl/heartbeat_gapcnt.sv
// Saturating cycle counter measuring time since the last beat/miss/clear.
module heartbeat_gapcnt
    import heartbeat_pkg::*;
#(
    parameter int unsigned W       = HB_DEF_W,
    parameter int unsigned TIMEOUT = HB_DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    output logic [W-1:0] gap,
    output logic         at_timeout
);

    localparam logic [W-1:0] GAP_TIMEOUT = W'(TIMEOUT - 1);
    localparam logic [W-1:0] GAP_MAX     = '1;

    // Count up every cycle, hold at all-ones, restart from zero on clear.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            gap <= '0;
        end else if (gap != GAP_MAX) begin
            gap <= gap + W'(1);
        end
    end

    // TIMEOUT cycles have elapsed since the last clear.
    assign at_timeout = (gap == GAP_TIMEOUT);

endmodule

// File: rtl/heartbeat_monitor.sv
// Heartbeat watchdog: locks onto the beat stream, measures the interval,
// flags early/missing beats and raises a sticky alarm after repeated faults.
module heartbeat_monitor
    import heartbeat_pkg::*;
#(
    parameter int unsigned W          = HB_DEF_W,
    parameter int unsigned TIMEOUT    = HB_DEF_TIMEOUT,
    parameter int unsigned MIN_PERIOD = HB_DEF_MIN_PERIOD,
    parameter int unsigned MISS_LIMIT = HB_DEF_MISS_LIMIT,
    parameter int unsigned CW         = HB_DEF_CW
) (
    input  logic               clk,
    input  logic               reset,
    heartbeat_monitor_if.slave bus
);

    localparam logic [W-1:0]  MIN_IV  = W'(MIN_PERIOD);
    localparam logic [W-1:0]  GAP_MAX = '1;
    localparam logic [CW-1:0] LIMIT   = CW'(MISS_LIMIT);

    hb_state_e     state_q;
    hb_state_e     state_d;

    logic          hb_q;
    logic          beat;
    logic          beat_ok;

    logic [W-1:0]  gap;
    logic          at_timeout;
    logic          gap_clr;
    logic [W-1:0]  interval;

    logic          counting;
    logic          good_beat;
    logic          early_beat;
    logic          miss;
    logic          fault;

    logic [CW-1:0] miss_q;
    logic [CW-1:0] miss_inc;
    logic          hit_limit;

    logic [W-1:0]  period_q;
    logic          period_vld_q;
    logic          early_q;
    logic          alive_d;
    logic          alarm_d;

    // Delay hb_in by one cycle so a rising edge can be detected.
    always_ff @(posedge clk) begin
        if (reset) begin
            hb_q <= 1'b0;
        end else begin
            hb_q <= bus.hb_in;
        end
    end

    assign beat    = bus.hb_in & ~hb_q;
    // alarm_clr wins over a coincident beat; the beat is discarded.
    assign beat_ok = beat & ~bus.alarm_clr;

    heartbeat_gapcnt #(
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) u_gapcnt (
        .clk        (clk),
        .reset      (reset),
        .clr        (gap_clr),
        .gap        (gap),
        .at_timeout (at_timeout)
    );

    // Interval of a beat is gap+1, held at all-ones once the counter saturates.
    assign interval = (gap == GAP_MAX) ? GAP_MAX : gap + W'(1);

    // Timeouts and early beats only count while locked and not yet alarmed.
    assign counting   = (state_q == ACTIVE) || (state_q == LATE);
    assign good_beat  = counting & beat_ok & (interval >= MIN_IV);
    assign early_beat = counting & beat_ok & (interval < MIN_IV);
    // A beat landing on the timeout cycle is on time, not a miss.
    assign miss       = counting & at_timeout & ~beat & ~bus.alarm_clr;
    assign fault      = early_beat | miss;
    assign gap_clr    = beat | miss | bus.alarm_clr;

    assign miss_inc  = (miss_q >= LIMIT) ? LIMIT : miss_q + CW'(1);
    assign hit_limit = (miss_inc == LIMIT);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (bus.alarm_clr) begin
            state_d = SEARCH;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (beat) begin
                        state_d = ACTIVE;
                    end
                end
                ACTIVE, LATE: begin
                    if (fault) begin
                        state_d = hit_limit ? ALARM : LATE;
                    end else if (good_beat) begin
                        state_d = ACTIVE;
                    end
                end
                ALARM: begin
                    state_d = ALARM;
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // FSM status outputs decoded from the state register.
    always_comb begin
        alive_d = (state_q == ACTIVE);
        alarm_d = (state_q == ALARM);
    end

    // Fault counter, period measurement and early pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_q       <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            early_q      <= 1'b0;
        end else begin
            early_q <= early_beat;
            if (bus.alarm_clr) begin
                miss_q       <= '0;
                period_vld_q <= 1'b0;
            end else begin
                if (fault) begin
                    miss_q <= miss_inc;
                end else if (good_beat) begin
                    miss_q <= '0;
                end
                // The first beat after SEARCH only establishes the phase.
                if (beat_ok && (state_q != SEARCH)) begin
                    period_q     <= interval;
                    period_vld_q <= 1'b1;
                end
            end
        end
    end

    assign bus.alive      = alive_d;
    assign bus.alarm      = alarm_d;
    assign bus.early      = early_q;
    assign bus.miss_count = miss_q;
    assign bus.period     = period_q;
    assign bus.period_vld = period_vld_q;

endmodule
